// File: rtl/obstacle_pkg.sv
// Shared types and defaults for the obstacle frame buffer.
// Optional feature macro: OBSTACLE_BBOX_EN (per-obstacle bounding boxes).
package obstacle_pkg;

  localparam int DEF_WORLD_BITS              = 32;
  localparam int DEF_MAX_NUM_VERTICES        = 8;
  localparam int DEF_MAX_OBSTACLES_ON_SCREEN = 16;

  typedef struct packed {
    logic signed [DEF_WORLD_BITS-1:0] x;
    logic signed [DEF_WORLD_BITS-1:0] y;
  } vertex_t;

  typedef struct packed {
    logic signed [DEF_WORLD_BITS-1:0] xmin;
    logic signed [DEF_WORLD_BITS-1:0] xmax;
    logic signed [DEF_WORLD_BITS-1:0] ymin;
    logic signed [DEF_WORLD_BITS-1:0] ymax;
  } bbox_t;

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } fb_state_t;

endpackage

// File: rtl/obstacle_frame_buffer_if.sv
// Vertex stream into the obstacle frame buffer: framed vertices plus the
// end-of-frame strobe. Optional feature macro: OBSTACLE_BBOX_EN (no effect here).
interface obstacle_frame_buffer_if #(
  parameter int WORLD_BITS = obstacle_pkg::DEF_WORLD_BITS
);
  logic                         valid_in;
  logic                         last_in;
  logic signed [WORLD_BITS-1:0] x_in;
  logic signed [WORLD_BITS-1:0] y_in;
  logic                         done_in;

  modport master (output valid_in, last_in, x_in, y_in, done_in);
  modport slave  (input  valid_in, last_in, x_in, y_in, done_in);
endinterface

// File: rtl/obstacle_bank.sv
// One bank of obstacle storage: vertex/side-count write port and a read port
// whose address is registered, so data appears one cycle after the address.
// Optional feature macro: OBSTACLE_BBOX_EN adds per-obstacle bounding boxes.
module obstacle_bank #(
  parameter int WORLD_BITS              = obstacle_pkg::DEF_WORLD_BITS,
  parameter int MAX_NUM_VERTICES        = obstacle_pkg::DEF_MAX_NUM_VERTICES,
  parameter int MAX_OBSTACLES_ON_SCREEN = obstacle_pkg::DEF_MAX_OBSTACLES_ON_SCREEN
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         vtx_we,
  input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0]   wr_obstacle,
  input  logic [$clog2(MAX_NUM_VERTICES)-1:0]          wr_vertex,
  input  logic signed [WORLD_BITS-1:0]                 wr_x,
  input  logic signed [WORLD_BITS-1:0]                 wr_y,
  input  logic                                         sides_we,
  input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]        wr_sides,
`ifdef OBSTACLE_BBOX_EN
  input  logic signed [WORLD_BITS-1:0]                 wr_xmin,
  input  logic signed [WORLD_BITS-1:0]                 wr_xmax,
  input  logic signed [WORLD_BITS-1:0]                 wr_ymin,
  input  logic signed [WORLD_BITS-1:0]                 wr_ymax,
  output logic signed [WORLD_BITS-1:0]                 rd_xmin,
  output logic signed [WORLD_BITS-1:0]                 rd_xmax,
  output logic signed [WORLD_BITS-1:0]                 rd_ymin,
  output logic signed [WORLD_BITS-1:0]                 rd_ymax,
`endif
  input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0]   rd_obstacle,
  input  logic [$clog2(MAX_NUM_VERTICES)-1:0]          rd_vertex,
  output logic signed [WORLD_BITS-1:0]                 rd_x,
  output logic signed [WORLD_BITS-1:0]                 rd_y,
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]        rd_sides
);
  import obstacle_pkg::*;

  localparam int OBS_W  = $clog2(MAX_OBSTACLES_ON_SCREEN);
  localparam int VTX_W  = $clog2(MAX_NUM_VERTICES);
  localparam int SIDE_W = $clog2(MAX_NUM_VERTICES + 1);
  localparam logic [OBS_W:0] OBS_LIMIT = (OBS_W+1)'(MAX_OBSTACLES_ON_SCREEN);
  localparam logic [VTX_W:0] VTX_LIMIT = (VTX_W+1)'(MAX_NUM_VERTICES);

  logic signed [WORLD_BITS-1:0] mem_x [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] mem_y [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES];
  logic [SIDE_W-1:0]            mem_sides [MAX_OBSTACLES_ON_SCREEN];
`ifdef OBSTACLE_BBOX_EN
  logic signed [WORLD_BITS-1:0] mem_xmin [MAX_OBSTACLES_ON_SCREEN];
  logic signed [WORLD_BITS-1:0] mem_xmax [MAX_OBSTACLES_ON_SCREEN];
  logic signed [WORLD_BITS-1:0] mem_ymin [MAX_OBSTACLES_ON_SCREEN];
  logic signed [WORLD_BITS-1:0] mem_ymax [MAX_OBSTACLES_ON_SCREEN];
`endif
  logic [OBS_W-1:0] rd_obstacle_q;
  logic [VTX_W-1:0] rd_vertex_q;

  // Storage writes; reset clears everything so reads return zero afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < MAX_OBSTACLES_ON_SCREEN; o++) begin
        mem_sides[o] <= '0;
`ifdef OBSTACLE_BBOX_EN
        mem_xmin[o] <= '0;
        mem_xmax[o] <= '0;
        mem_ymin[o] <= '0;
        mem_ymax[o] <= '0;
`endif
        for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
          mem_x[o][v] <= '0;
          mem_y[o][v] <= '0;
        end
      end
    end else begin
      if (vtx_we) begin
        mem_x[wr_obstacle][wr_vertex] <= wr_x;
        mem_y[wr_obstacle][wr_vertex] <= wr_y;
      end
      if (sides_we) begin
        mem_sides[wr_obstacle] <= wr_sides;
`ifdef OBSTACLE_BBOX_EN
        mem_xmin[wr_obstacle] <= wr_xmin;
        mem_xmax[wr_obstacle] <= wr_xmax;
        mem_ymin[wr_obstacle] <= wr_ymin;
        mem_ymax[wr_obstacle] <= wr_ymax;
`endif
      end
    end
  end

  // Capture the read address; data is looked up from the registered address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_obstacle_q <= '0;
      rd_vertex_q   <= '0;
    end else begin
      rd_obstacle_q <= rd_obstacle;
      rd_vertex_q   <= rd_vertex;
    end
  end

  // Read lookup; out-of-range indices return zero instead of indexing past the array
  always_comb begin
    rd_x     = '0;
    rd_y     = '0;
    rd_sides = '0;
`ifdef OBSTACLE_BBOX_EN
    rd_xmin = '0;
    rd_xmax = '0;
    rd_ymin = '0;
    rd_ymax = '0;
`endif
    if ({1'b0, rd_obstacle_q} < OBS_LIMIT) begin
      rd_sides = mem_sides[rd_obstacle_q];
`ifdef OBSTACLE_BBOX_EN
      rd_xmin = mem_xmin[rd_obstacle_q];
      rd_xmax = mem_xmax[rd_obstacle_q];
      rd_ymin = mem_ymin[rd_obstacle_q];
      rd_ymax = mem_ymax[rd_obstacle_q];
`endif
      if ({1'b0, rd_vertex_q} < VTX_LIMIT) begin
        rd_x = mem_x[rd_obstacle_q][rd_vertex_q];
        rd_y = mem_y[rd_obstacle_q][rd_vertex_q];
      end
    end
  end

endmodule

// File: rtl/obstacle_frame_buffer.sv
// Double-buffered obstacle table: collects framed polygon vertices into the
// back bank while consumers read the front bank; done_in swaps the banks.
// Optional feature macro: OBSTACLE_BBOX_EN adds per-obstacle bounding boxes.
module obstacle_frame_buffer #(
  parameter int WORLD_BITS              = obstacle_pkg::DEF_WORLD_BITS,
  parameter int MAX_NUM_VERTICES        = obstacle_pkg::DEF_MAX_NUM_VERTICES,
  parameter int MAX_OBSTACLES_ON_SCREEN = obstacle_pkg::DEF_MAX_OBSTACLES_ON_SCREEN
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  obstacle_frame_buffer_if.slave                       stream,
  input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0]   rd_obstacle_in,
  input  logic [$clog2(MAX_NUM_VERTICES)-1:0]          rd_vertex_in,
  output logic signed [WORLD_BITS-1:0]                 rd_x_out,
  output logic signed [WORLD_BITS-1:0]                 rd_y_out,
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]        rd_num_sides_out,
  output logic [$clog2(MAX_OBSTACLES_ON_SCREEN+1)-1:0] num_obstacles_out,
  output logic                                         overflow_out,
  output logic                                         bank_out,
  output logic                                         done_out
`ifdef OBSTACLE_BBOX_EN
  ,
  output logic signed [WORLD_BITS-1:0]                 rd_xmin_out,
  output logic signed [WORLD_BITS-1:0]                 rd_xmax_out,
  output logic signed [WORLD_BITS-1:0]                 rd_ymin_out,
  output logic signed [WORLD_BITS-1:0]                 rd_ymax_out
`endif
);
  import obstacle_pkg::*;

  localparam int OBS_W  = $clog2(MAX_OBSTACLES_ON_SCREEN);
  localparam int VTX_W  = $clog2(MAX_NUM_VERTICES);
  localparam int SIDE_W = $clog2(MAX_NUM_VERTICES + 1);
  localparam int CNT_W  = $clog2(MAX_OBSTACLES_ON_SCREEN + 1);
  localparam logic [CNT_W-1:0]  OBS_FULL  = CNT_W'(MAX_OBSTACLES_ON_SCREEN);
  localparam logic [SIDE_W-1:0] SIDE_FULL = SIDE_W'(MAX_NUM_VERTICES);
  localparam logic [SIDE_W-1:0] SIDE_MIN  = SIDE_W'(3);

  fb_state_t         state, nxt_state;
  logic [CNT_W-1:0]  wr_idx, nxt_wr_idx;
  logic [SIDE_W-1:0] sides, nxt_sides;
  logic              drop_poly, nxt_drop;
  logic              ovf_pend, nxt_ovf;
  logic              vtx_we;
  logic [VTX_W-1:0]  vtx_slot;
  logic              close_poly;
  logic              commit;

  logic signed [WORLD_BITS-1:0] bank_rd_x [2];
  logic signed [WORLD_BITS-1:0] bank_rd_y [2];
  logic [SIDE_W-1:0]            bank_rd_sides [2];
`ifdef OBSTACLE_BBOX_EN
  logic signed [WORLD_BITS-1:0] xmin, xmax, ymin, ymax;
  logic signed [WORLD_BITS-1:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
  logic signed [WORLD_BITS-1:0] bank_rd_xmin [2];
  logic signed [WORLD_BITS-1:0] bank_rd_xmax [2];
  logic signed [WORLD_BITS-1:0] bank_rd_ymin [2];
  logic signed [WORLD_BITS-1:0] bank_rd_ymax [2];
`endif

  // Polygon framing: accept the vertex first, then close on last_in or a coincident done_in
  always_comb begin
    nxt_state  = state;
    nxt_sides  = sides;
    nxt_drop   = drop_poly;
    nxt_ovf    = ovf_pend;
    vtx_we     = 1'b0;
    vtx_slot   = '0;
    close_poly = 1'b0;
    if (stream.valid_in) begin
      if (state == CLOSED) begin
        nxt_state = OPEN;
        nxt_sides = SIDE_W'(1);
        nxt_drop  = 1'b0;
        if (wr_idx == OBS_FULL) begin
          nxt_drop = 1'b1;
          nxt_ovf  = 1'b1;
        end else begin
          vtx_we = 1'b1;
        end
      end else if (!drop_poly) begin
        if (sides == SIDE_FULL) begin
          nxt_ovf = 1'b1;
        end else begin
          vtx_we    = 1'b1;
          vtx_slot  = sides[VTX_W-1:0];
          nxt_sides = sides + SIDE_W'(1);
        end
      end
      if (stream.last_in) close_poly = 1'b1;
    end
    if (stream.done_in && nxt_state == OPEN) close_poly = 1'b1;
    if (close_poly) nxt_state = CLOSED;
    commit     = close_poly && !nxt_drop && (nxt_sides >= SIDE_MIN);
    nxt_wr_idx = wr_idx + CNT_W'(commit);
  end

  // Collector state and frame publication; done_in swaps banks and empties the back bank
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state             <= CLOSED;
      wr_idx            <= '0;
      sides             <= '0;
      drop_poly         <= 1'b0;
      ovf_pend          <= 1'b0;
      bank_out          <= 1'b0;
      num_obstacles_out <= '0;
      overflow_out      <= 1'b0;
      done_out          <= 1'b0;
    end else if (stream.done_in) begin
      state             <= CLOSED;
      wr_idx            <= '0;
      sides             <= '0;
      drop_poly         <= 1'b0;
      ovf_pend          <= 1'b0;
      bank_out          <= ~bank_out;
      num_obstacles_out <= nxt_wr_idx;
      overflow_out      <= nxt_ovf;
      done_out          <= 1'b1;
    end else begin
      state     <= nxt_state;
      wr_idx    <= nxt_wr_idx;
      sides     <= nxt_sides;
      drop_poly <= nxt_drop;
      ovf_pend  <= nxt_ovf;
      done_out  <= 1'b0;
    end
  end

`ifdef OBSTACLE_BBOX_EN
  // Running bounding box of the open polygon; the first stored vertex seeds it
  always_comb begin
    nxt_xmin = xmin;
    nxt_xmax = xmax;
    nxt_ymin = ymin;
    nxt_ymax = ymax;
    if (vtx_we) begin
      if (state == CLOSED) begin
        nxt_xmin = stream.x_in;
        nxt_xmax = stream.x_in;
        nxt_ymin = stream.y_in;
        nxt_ymax = stream.y_in;
      end else begin
        if (stream.x_in < xmin) nxt_xmin = stream.x_in;
        if (stream.x_in > xmax) nxt_xmax = stream.x_in;
        if (stream.y_in < ymin) nxt_ymin = stream.y_in;
        if (stream.y_in > ymax) nxt_ymax = stream.y_in;
      end
    end
  end

  // Bounding box registers for the polygon being collected
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
    end else begin
      xmin <= nxt_xmin;
      xmax <= nxt_xmax;
      ymin <= nxt_ymin;
      ymax <= nxt_ymax;
    end
  end
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    // Bank b is the back bank whenever the front index points at the other one
    obstacle_bank #(
      .WORLD_BITS              (WORLD_BITS),
      .MAX_NUM_VERTICES        (MAX_NUM_VERTICES),
      .MAX_OBSTACLES_ON_SCREEN (MAX_OBSTACLES_ON_SCREEN)
    ) u_bank (
      .clk         (clk_in),
      .rst_n       (rst_n_in),
      .vtx_we      (vtx_we && (bank_out != 1'(b))),
      .wr_obstacle (wr_idx[OBS_W-1:0]),
      .wr_vertex   (vtx_slot),
      .wr_x        (stream.x_in),
      .wr_y        (stream.y_in),
      .sides_we    (commit && (bank_out != 1'(b))),
      .wr_sides    (nxt_sides),
`ifdef OBSTACLE_BBOX_EN
      .wr_xmin     (nxt_xmin),
      .wr_xmax     (nxt_xmax),
      .wr_ymin     (nxt_ymin),
      .wr_ymax     (nxt_ymax),
      .rd_xmin     (bank_rd_xmin[b]),
      .rd_xmax     (bank_rd_xmax[b]),
      .rd_ymin     (bank_rd_ymin[b]),
      .rd_ymax     (bank_rd_ymax[b]),
`endif
      .rd_obstacle (rd_obstacle_in),
      .rd_vertex   (rd_vertex_in),
      .rd_x        (bank_rd_x[b]),
      .rd_y        (bank_rd_y[b]),
      .rd_sides    (bank_rd_sides[b])
    );
  end

  // Present the front bank's read data
  always_comb begin
    rd_x_out         = bank_rd_x[bank_out];
    rd_y_out         = bank_rd_y[bank_out];
    rd_num_sides_out = bank_rd_sides[bank_out];
`ifdef OBSTACLE_BBOX_EN
    rd_xmin_out = bank_rd_xmin[bank_out];
    rd_xmax_out = bank_rd_xmax[bank_out];
    rd_ymin_out = bank_rd_ymin[bank_out];
    rd_ymax_out = bank_rd_ymax[bank_out];
`endif
  end

endmodule

// File: tb/tb_obstacle_frame_buffer.sv
// Scoreboard bench for obstacle_frame_buffer: stimulus queues expected frames
// and reads, a monitor compares them when done_out / read data appear.
// Optional feature macro: OBSTACLE_BBOX_EN enables the bounding-box checks.
module tb_obstacle_frame_buffer;
  import obstacle_pkg::*;

  localparam int WB = 32;

  typedef struct {
    int   count;
    logic ovf;
    logic bank;
  } frame_exp_t;

  typedef struct {
    int      sides;
    vertex_t v;
    bbox_t   bb;
    logic    has_bb;
  } read_exp_t;

  logic clk = 1'b0;
  logic rst_n_in;
  logic [3:0] rd_obstacle_in;
  logic [2:0] rd_vertex_in;
  logic signed [WB-1:0] rd_x_out, rd_y_out;
  logic [3:0] rd_num_sides_out;
  logic [4:0] num_obstacles_out;
  logic overflow_out, bank_out, done_out;
`ifdef OBSTACLE_BBOX_EN
  logic signed [WB-1:0] rd_xmin_out, rd_xmax_out, rd_ymin_out, rd_ymax_out;
`endif

  frame_exp_t frame_q [$];
  read_exp_t  read_q [$];
  int n_checks = 0;
  int n_fail = 0;
  logic exp_bank = 1'b0;
  logic rd_req = 1'b0;
  logic rd_check = 1'b0;

  always #5 clk = ~clk;

  obstacle_frame_buffer_if #(.WORLD_BITS(WB)) stream ();

  obstacle_frame_buffer dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n_in),
    .stream            (stream),
    .rd_obstacle_in    (rd_obstacle_in),
    .rd_vertex_in      (rd_vertex_in),
    .rd_x_out          (rd_x_out),
    .rd_y_out          (rd_y_out),
    .rd_num_sides_out  (rd_num_sides_out),
    .num_obstacles_out (num_obstacles_out),
    .overflow_out      (overflow_out),
    .bank_out          (bank_out),
    .done_out          (done_out)
`ifdef OBSTACLE_BBOX_EN
    ,
    .rd_xmin_out       (rd_xmin_out),
    .rd_xmax_out       (rd_xmax_out),
    .rd_ymin_out       (rd_ymin_out),
    .rd_ymax_out       (rd_ymax_out)
`endif
  );

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic d,
                               input int x, input int y);
    stream.valid_in = v;
    stream.last_in  = l;
    stream.done_in  = d;
    stream.x_in     = x;
    stream.y_in     = y;
    @(posedge clk);
    #1;
    stream.valid_in = 1'b0;
    stream.last_in  = 1'b0;
    stream.done_in  = 1'b0;
  endtask

  task automatic expectFrame(input int count, input logic ovf);
    frame_exp_t e;
    exp_bank = ~exp_bank;
    e.count = count;
    e.ovf   = ovf;
    e.bank  = exp_bank;
    frame_q.push_back(e);
  endtask

  task automatic issueRead(input int obs, input int vtx, input read_exp_t e);
    read_q.push_back(e);
    rd_obstacle_in = 4'(obs);
    rd_vertex_in   = 3'(vtx);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic readVertex(input int obs, input int vtx, input int sides,
                            input int x, input int y);
    read_exp_t e;
    e.sides  = sides;
    e.v.x    = x;
    e.v.y    = y;
    e.bb     = '0;
    e.has_bb = 1'b0;
    issueRead(obs, vtx, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_in = 1'b1;
    exp_bank = 1'b0;
    checkOutput("rst_x", rd_x_out, 0);
    checkOutput("rst_y", rd_y_out, 0);
    checkOutput("rst_sides", rd_num_sides_out, 0);
    checkOutput("rst_count", num_obstacles_out, 0);
    checkOutput("rst_ovf", overflow_out, 0);
    checkOutput("rst_bank", bank_out, 0);
    checkOutput("rst_done", done_out, 0);
  endtask

  // Read data becomes valid one cycle after the address was presented
  always @(posedge clk) rd_check <= rd_req;

  // Monitor: pop and compare whenever a swap or a read result is presented
  always @(negedge clk) begin
    if (done_out) begin
      if (frame_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done_out 1, expected 0");
      end else begin
        frame_exp_t f;
        f = frame_q.pop_front();
        checkOutput("frame_count", num_obstacles_out, f.count);
        checkOutput("frame_ovf", overflow_out, f.ovf);
        checkOutput("frame_bank", bank_out, f.bank);
      end
    end
    if (rd_check) begin
      read_exp_t r;
      r = read_q.pop_front();
      checkOutput("read_sides", rd_num_sides_out, r.sides);
      checkOutput("read_x", rd_x_out, r.v.x);
      checkOutput("read_y", rd_y_out, r.v.y);
`ifdef OBSTACLE_BBOX_EN
      if (r.has_bb) begin
        checkOutput("read_xmin", rd_xmin_out, r.bb.xmin);
        checkOutput("read_xmax", rd_xmax_out, r.bb.xmax);
        checkOutput("read_ymin", rd_ymin_out, r.bb.ymin);
        checkOutput("read_ymax", rd_ymax_out, r.bb.ymax);
      end
`endif
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stream.valid_in = 1'b0;
    stream.last_in  = 1'b0;
    stream.done_in  = 1'b0;
    stream.x_in     = '0;
    stream.y_in     = '0;
    rd_obstacle_in  = '0;
    rd_vertex_in    = '0;
    doReset();

    $display("[TB] triangle");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 10, 0);
    applyStimulus(1, 1, 0, 0, 10);
    expectFrame(1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    readVertex(0, 0, 3, 0, 0);
    readVertex(0, 1, 3, 10, 0);
    readVertex(0, 2, 3, 0, 10);

    $display("[TB] degenerate then square");
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 2, 2);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 5, 0);
    applyStimulus(1, 0, 0, 5, 5);
    applyStimulus(1, 1, 0, 0, 5);
    expectFrame(1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    readVertex(0, 0, 4, 0, 0);
    readVertex(0, 1, 4, 5, 0);
    readVertex(0, 3, 4, 0, 5);

    $display("[TB] vertex overflow");
    for (int i = 0; i < 10; i++) applyStimulus(1, (i == 9), 0, i, 100 + i);
    expectFrame(1, 1);
    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) readVertex(0, i, 8, i, 100 + i);

    $display("[TB] obstacle overflow");
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1, 0, 0, k, 0);
      applyStimulus(1, 0, 0, k + 1, 0);
      applyStimulus(1, 1, 0, k, 1);
    end
    expectFrame(16, 1);
    applyStimulus(0, 0, 1, 0, 0);
    readVertex(15, 1, 3, 16, 0);
    readVertex(0, 2, 3, 0, 1);
    applyStimulus(1, 0, 0, 50, 50);
    applyStimulus(1, 0, 0, 60, 50);
    applyStimulus(1, 1, 0, 50, 60);
    expectFrame(1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    readVertex(0, 2, 3, 50, 60);

    $display("[TB] done with third vertex");
    applyStimulus(1, 0, 0, 1, 2);
    applyStimulus(1, 0, 0, 3, 4);
    expectFrame(1, 0);
    applyStimulus(1, 0, 1, 5, 6);
    readVertex(0, 2, 3, 5, 6);

    $display("[TB] back-to-back done");
    expectFrame(0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    expectFrame(0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    idle(2);

`ifdef OBSTACLE_BBOX_EN
    $display("[TB] bounding box");
    applyStimulus(1, 0, 0, -5, 7);
    applyStimulus(1, 0, 0, 3, -2);
    applyStimulus(1, 1, 0, 1, 9);
    expectFrame(1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    begin
      read_exp_t e;
      e.sides   = 3;
      e.v.x     = -5;
      e.v.y     = 7;
      e.bb.xmin = -5;
      e.bb.xmax = 3;
      e.bb.ymin = -2;
      e.bb.ymax = 9;
      e.has_bb  = 1'b1;
      issueRead(0, 0, e);
    end
`endif

    $display("[TB] reset mid-polygon");
    idle(2);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 2, 2);
    doReset();
    applyStimulus(1, 1, 0, 7, 7);
    applyStimulus(1, 0, 0, 20, 20);
    applyStimulus(1, 0, 0, 30, 20);
    applyStimulus(1, 1, 0, 20, 30);
    expectFrame(1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    readVertex(0, 0, 3, 20, 20);

    for (int i = 0; i < 50 && (frame_q.size() != 0 || read_q.size() != 0); i++) idle(1);
    checkOutput("frames_pending", frame_q.size(), 0);
    checkOutput("reads_pending", read_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
